// File: rtl/led_event_driver.sv
// LED event driver: each clk-domain event pulse becomes an ON pulse plus a guaranteed OFF gap,
// with busy-time events queued in a saturating counter. Define LED_ACTIVE_LOW_EN for an active-low pin.
module led_event_driver #(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500,
  parameter int CNT_W      = 16,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_in,
  input  logic              clr_ovf,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LIT = 1'b0;
`else
  localparam logic LIT = 1'b1;
`endif

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PEND_W-1:0] pending_n;
  logic              overflow_n;
  logic              led_n;
  logic              busy_n;
  logic              last_off;
  logic              inc;
  logic              dec;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pending_n  = pending;
    overflow_n = overflow;

    last_off = (state == ST_OFF) && (cnt == '0);

    case (state)
      ST_IDLE: begin
        if (evt_in) begin
          state_n = ST_ON;
          cnt_n   = ON_LOAD;
        end
      end
      ST_ON: begin
        if (cnt == '0) begin
          state_n = ST_OFF;
          cnt_n   = OFF_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (cnt == '0) begin
          if ((pending != '0) || evt_in) begin
            state_n = ST_ON;
            cnt_n   = ON_LOAD;
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // An event on the last OFF cycle with an empty queue starts the next pulse directly.
    inc = (state != ST_IDLE) && evt_in && !(last_off && (pending == '0));
    dec = last_off && (pending != '0);

    if (inc && !dec) begin
      if (pending == PEND_MAX) overflow_n = 1'b1;
      else                     pending_n  = pending + PEND_W'(1);
    end else if (dec && !inc) begin
      pending_n = pending - PEND_W'(1);
    end

    // A dropped event in the same cycle as a clear leaves the flag set.
    if (clr_ovf && !(inc && !dec && (pending == PEND_MAX))) overflow_n = 1'b0;

    // Pin and busy are derived from the next state so they toggle only on transitions.
    led_n  = (state_n == ST_ON) ? LIT : ~LIT;
    busy_n = (state_n != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      led_out  <= ~LIT;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pending  <= pending_n;
      overflow <= overflow_n;
      led_out  <= led_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_led_event_driver.sv
// Table-driven bench for led_event_driver: each record is a 40-cycle scenario with per-cycle
// input and expected-output characters; expected LED is given lit=1 and mapped to pin polarity.
module tb_led_event_driver;

  localparam int ON_CYCLES  = 4;
  localparam int OFF_CYCLES = 3;
  localparam int CNT_W      = 16;
  localparam int PEND_W     = 2;
  localparam int N          = 40;
  localparam int NVEC       = 7;

  localparam bit [79:0] Z = "0000000000";

  typedef bit [8*N-1:0] track_t;

  typedef struct packed {
    bit [8*8-1:0] name;
    track_t       t_rst;
    track_t       t_evt;
    track_t       t_clr;
    track_t       t_led;
    track_t       t_busy;
    track_t       t_pend;
    track_t       t_ovf;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              evt_in = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  vec_t vecs [NVEC];

  led_event_driver #(
    .ON_CYCLES (ON_CYCLES),
    .OFF_CYCLES(OFF_CYCLES),
    .CNT_W     (CNT_W),
    .PEND_W    (PEND_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .evt_in  (evt_in),
    .clr_ovf (clr_ovf),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int chr(input track_t s, input int i);
    bit [7:0] c;
    c = s[8*(N-1-i) +: 8];
    return int'(c) - 48;
  endfunction

  function automatic int lit_to_pin(input int lit);
`ifdef LED_ACTIVE_LOW_EN
    return 1 - lit;
`else
    return lit;
`endif
  endfunction

  task automatic check(input string what, input string scen, input int cyc,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s scen=%s cycle=%0d got=%0d expected=%0d", what, scen, cyc, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    string scen;
    scen = $sformatf("%s", v.name);
    rst     = 1'b1;
    evt_in  = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rst = (chr(v.t_rst, i) == 1);
      if (rst) begin
        evt_in  = 1'b0;
        clr_ovf = 1'b0;
      end
      #1;
      check("led_out",  scen, i, int'(led_out),  lit_to_pin(chr(v.t_led, i)));
      check("busy",     scen, i, int'(busy),     chr(v.t_busy, i));
      check("pending",  scen, i, int'(pending),  chr(v.t_pend, i));
      check("overflow", scen, i, int'(overflow), chr(v.t_ovf, i));
      if (!rst) begin
        evt_in  = (chr(v.t_evt, i) == 1);
        clr_ovf = (chr(v.t_clr, i) == 1);
      end
      @(negedge clk);
    end
    rst     = 1'b1;
    evt_in  = 1'b0;
    clr_ovf = 1'b0;
  endtask

  initial begin
    // Idle after reset: everything stays at reset values.
    vecs[0] = '{name: "idle",
      t_rst:  {Z, Z, Z, Z},
      t_evt:  {Z, Z, Z, Z},
      t_clr:  {Z, Z, Z, Z},
      t_led:  {Z, Z, Z, Z},
      t_busy: {Z, Z, Z, Z},
      t_pend: {Z, Z, Z, Z},
      t_ovf:  {Z, Z, Z, Z}};

    // Single event at cycle 10: lit 11-14, busy 11-17.
    vecs[1] = '{name: "single",
      t_rst:  {Z, Z, Z, Z},
      t_evt:  {Z, "1000000000", Z, Z},
      t_clr:  {Z, Z, Z, Z},
      t_led:  {Z, "0111100000", Z, Z},
      t_busy: {Z, "0111111100", Z, Z},
      t_pend: {Z, Z, Z, Z},
      t_ovf:  {Z, Z, Z, Z}};

    // Three back-to-back events are queued and shown as three separate pulses.
    vecs[2] = '{name: "burst3",
      t_rst:  {Z, Z, Z, Z},
      t_evt:  {Z, "1110000000", Z, Z},
      t_clr:  {Z, Z, Z, Z},
      t_led:  {Z, "0111100011", "1100011110", Z},
      t_busy: {Z, "0111111111", "1111111111", "1100000000"},
      t_pend: {Z, "0012222211", "1111100000", Z},
      t_ovf:  {Z, Z, Z, Z}};

    // Saturation, overflow, clear, and clear coincident with a dropped event.
    vecs[3] = '{name: "ovf",
      t_rst:  {Z, Z, Z, Z},
      t_evt:  {Z, "1111110000", "0111000000", Z},
      t_clr:  {Z, Z, "1001001000", Z},
      t_led:  {Z, "0111100011", "1100011110", "0011110001"},
      t_busy: {Z, "0111111111", "1111111111", "1111111111"},
      t_pend: {Z, "0012333322", "2233322222", "2211111110"},
      t_ovf:  {Z, "0000011111", "1001111000", Z}};

    // Event on the final OFF cycle with one queued: restart ON, pending stays 1.
    vecs[4] = '{name: "lastq",
      t_rst:  {Z, Z, Z, Z},
      t_evt:  {Z, "1100000100", Z, Z},
      t_clr:  {Z, Z, Z, Z},
      t_led:  {Z, "0111100011", "1100011110", Z},
      t_busy: {Z, "0111111111", "1111111111", "1100000000"},
      t_pend: {Z, "0011111111", "1111100000", Z},
      t_ovf:  {Z, Z, Z, Z}};

    // Event on the final OFF cycle with empty queue: consumed directly, pending stays 0.
    vecs[5] = '{name: "last0",
      t_rst:  {Z, Z, Z, Z},
      t_evt:  {Z, "1000000100", Z, Z},
      t_clr:  {Z, Z, Z, Z},
      t_led:  {Z, "0111100011", "1100000000", Z},
      t_busy: {Z, "0111111111", "1111100000", Z},
      t_pend: {Z, Z, Z, Z},
      t_ovf:  {Z, Z, Z, Z}};

    // Asynchronous reset at cycle 12 mid-pulse, then a normal pulse from an event at 15.
    vecs[6] = '{name: "midrst",
      t_rst:  {Z, "0010000000", Z, Z},
      t_evt:  {"0000000001", "1000010000", Z, Z},
      t_clr:  {Z, Z, Z, Z},
      t_led:  {Z, "1100001111", Z, Z},
      t_busy: {Z, "1100001111", "1110000000", Z},
      t_pend: {Z, "0100000000", Z, Z},
      t_ovf:  {Z, Z, Z, Z}};

    // Outputs must hold reset values while reset is asserted.
    repeat (2) @(negedge clk);
    check("rst_led",  "reset", 0, int'(led_out),  lit_to_pin(0));
    check("rst_busy", "reset", 0, int'(busy),     0);
    check("rst_pend", "reset", 0, int'(pending),  0);
    check("rst_ovf",  "reset", 0, int'(overflow), 0);

    for (int k = 0; k < NVEC; k++) run_vec(vecs[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_event_driver.md
Name: led_event_driver

Overview:
Output-side companion to the button input synchroniser. It accepts single-cycle event pulses from clk-domain logic and drives a registered external LED pin. Each event becomes a visible ON pulse followed by a guaranteed OFF gap. Events that arrive while the LED is busy are queued in a saturating counter, so no event is visually merged with another.

Parameters:
ON_CYCLES, 1000, LED on-time per event in clk cycles; must be >= 1 and fit in CNT_W.
OFF_CYCLES, 500, minimum LED off-gap after each ON pulse in clk cycles; must be >= 1 and fit in CNT_W.
CNT_W, 16, width of the internal duration counter.
PEND_W, 4, width of the pending-event counter; maximum queued events is 2^PEND_W - 1.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
evt_in  input  1  event pulse, synchronous to clk; each cycle high counts as one event
clr_ovf  input  1  synchronous clear of overflow
led_out  output  1  registered LED drive, active-high unless LED_ACTIVE_LOW_EN is defined
busy  output  1  high while FSM is in ON or OFF
pending  output  PEND_W  number of queued events not yet displayed
overflow  output  1  sticky flag; an event was dropped because pending was saturated

Behaviour:
- Reset (asynchronous): FSM=IDLE, counter=0, led_out=0 (1 if active-low), busy=0, pending=0, overflow=0. All outputs are registered.
- FSM states: IDLE, ON, OFF.
- IDLE, evt_in=1: next cycle is ON, counter loaded with ON_CYCLES-1. Latency from evt_in to led_out asserted is 1 cycle.
- ON: led_out asserted. The counter decrements each cycle. When counter=0, next cycle is OFF and counter is loaded with OFF_CYCLES-1. led_out is asserted for exactly ON_CYCLES cycles.
- OFF: led_out deasserted. The counter decrements each cycle. When counter=0:
  - pending>0 or evt_in=1: next state is ON, counter loaded with ON_CYCLES-1.
  - otherwise: next state is IDLE.
  - led_out is deasserted for exactly OFF_CYCLES cycles between pulses.
- Pending update, applied only in ON or OFF (an event in IDLE starts ON directly and is not counted):
  - inc = evt_in.
  - dec = last OFF cycle and pending>0.
  - inc and dec in the same cycle: pending unchanged. On that cycle the FSM consumes a queued event; the new event stays queued.
  - Last OFF cycle with pending=0 and evt_in=1: the event is consumed directly, pending stays 0.
  - inc with pending at its maximum: pending holds its value and overflow is set.
- overflow: set has priority over clr_ovf when both occur in the same cycle.
- busy = (state != IDLE), registered with the state.
- A glitch-free LED is guaranteed: led_out changes only on state transitions.
- Reset mid-pulse: LED released immediately and the queue is discarded.

Optional Feature:
LED_ACTIVE_LOW_EN
- Defined: led_out polarity is inverted. Lit = 0, dark = 1, reset value = 1.
- Undefined: active-high, reset value = 0.
- FSM, busy, pending and overflow are identical in both builds.

Test Plan:
Bench params for all scenarios: ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
1. Reset, then idle 20 cycles -> led_out=0, busy=0, pending=0, overflow=0 throughout.
2. Single evt_in pulse at cycle 10 -> led_out=1 in cycles 11-14 and 0 from cycle 15; busy=1 in cycles 11-17 and 0 at cycle 18.
3. evt_in high in cycles 10, 11, 12 -> pending=1 at cycle 12 and 2 at cycle 13; LED pulses in cycles 11-14, 18-21 and 25-28; pending=1 at cycle 18 and 0 at cycle 25; busy=0 at cycle 32.
4. evt_in high in cycles 10-15 -> pending saturates at 3 and overflow=1 from cycle 15. clr_ovf at cycle 20 -> overflow=0 at cycle 21. clr_ovf coincident with a dropped event -> overflow stays 1.
5. pending=1, evt_in high on the final OFF cycle -> next cycle state is ON with pending still 1.
6. rst asserted at cycle 12 during ON -> led_out=0 and pending=0 immediately. After release, a new event produces a normal 4-cycle pulse.
